// File: rtl/bitpack_ssm.sv
// Substream packer: funnels MSB-aligned 0..128-bit SE chunks into fixed 128-bit words; flush drains a zero-padded last word.
// Latency: an accepted bit can appear on word_data the next cycle at the earliest.
// Backpressure: se_ready drops when the accumulator cannot take a full chunk and no word leaves this cycle; idle during flush.
module bitpack_ssm #(
    parameter int SSM_IDX = 0,
    parameter int WORD_W  = 128,
    parameter int CNT_W   = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              se_valid,
    output logic              se_ready,
    input  logic [WORD_W-1:0] se_bits,
    input  logic [7:0]        se_len,
    input  logic              flush_req,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [WORD_W-1:0] word_data,
    output logic              word_last,
    output logic              flush_done,
    output logic [7:0]        fill_level,
    output logic [CNT_W-1:0]  bits_total,
    output logic              err_len
);
    localparam int         ACC_W = 2 * WORD_W - 1;
    localparam logic [7:0] FULL  = 8'(WORD_W);

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_base, ins;
    logic [7:0]         fill_q, fill_d, fill_base, len;
    logic [WORD_W-1:0]  se_mask;
    logic               word_fire, se_fire;

    assign word_valid = (state_q == S_RUN   && fill_q >= FULL) ||
                        (state_q == S_FLUSH && fill_q != 8'd0);
    // The word that empties the accumulator during a flush is the last one.
    assign word_last  = (state_q == S_FLUSH) && (fill_q != 8'd0) && (fill_q <= FULL);
    assign word_fire  = word_valid & word_ready;
    assign se_ready   = (state_q == S_RUN) && ((fill_q < FULL) || word_fire);
    assign se_fire    = se_valid & se_ready;
    assign len        = (se_len > FULL) ? FULL : se_len;
    assign word_data  = acc_q[ACC_W-1 -: WORD_W];
    assign flush_done = (state_q == S_DONE);
    assign fill_level = fill_q;

    always_comb begin
        acc_base  = acc_q;
        fill_base = fill_q;
        se_mask   = ~({WORD_W{1'b1}} >> len);
        ins       = {se_bits & se_mask, {(WORD_W-1){1'b0}}} >> fill_base;
        if (word_fire) begin
            if (fill_q >= FULL) begin
                acc_base  = acc_q << WORD_W;
                fill_base = fill_q - FULL;
            end else begin
                acc_base  = '0;
                fill_base = 8'd0;
            end
            ins = {se_bits & se_mask, {(WORD_W-1){1'b0}}} >> fill_base;
        end
        acc_d  = acc_base;
        fill_d = fill_base;
        if (se_fire) begin
            acc_d  = acc_base | ins;
            fill_d = fill_base + len;
        end
        if (state_q == S_DONE) begin
            acc_d  = '0;
            fill_d = 8'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (flush_req) state_d = S_FLUSH;
            S_FLUSH: if (fill_q == 8'd0 || (word_fire && word_last)) state_d = S_DONE;
            S_DONE:  state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_RUN;
            acc_q      <= '0;
            fill_q     <= 8'd0;
            bits_total <= '0;
            err_len    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            if (se_fire) begin
                bits_total <= bits_total + CNT_W'(len);
                if (se_len > FULL) err_len <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bitpack_ssm.sv
// Directed table-driven bench for bitpack_ssm plus hand sequences for length error and reset mid-drain.
module tb_bitpack_ssm;
    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         se_valid = 1'b0;
    logic         se_ready;
    logic [127:0] se_bits = '0;
    logic [7:0]   se_len = '0;
    logic         flush_req = 1'b0;
    logic         word_valid;
    logic         word_ready = 1'b0;
    logic [127:0] word_data;
    logic         word_last;
    logic         flush_done;
    logic [7:0]   fill_level;
    logic [23:0]  bits_total;
    logic         err_len;

    int total = 0;
    int bad   = 0;

    bitpack_ssm #(.SSM_IDX(0), .WORD_W(128), .CNT_W(24)) dut (
        .clk(clk), .rstn(rstn),
        .se_valid(se_valid), .se_ready(se_ready), .se_bits(se_bits), .se_len(se_len),
        .flush_req(flush_req),
        .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
        .word_last(word_last), .flush_done(flush_done), .fill_level(fill_level),
        .bits_total(bits_total), .err_len(err_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [127:0] bits;
        logic [7:0]   len;
        logic         wr;
        logic         fl;
        logic [7:0]   e_fill;
        logic         e_rdy;
        logic         e_wvld;
        logic         e_last;
        logic         e_done;
        logic [127:0] e_data;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic v, input logic [127:0] bits, input logic [7:0] len,
                                input logic wr, input logic fl, input logic [7:0] e_fill,
                                input logic e_rdy, input logic e_wvld, input logic e_last,
                                input logic e_done, input logic [127:0] e_data);
        vec_t r;
        r.v = v; r.bits = bits; r.len = len; r.wr = wr; r.fl = fl;
        r.e_fill = e_fill; r.e_rdy = e_rdy; r.e_wvld = e_wvld;
        r.e_last = e_last; r.e_done = e_done; r.e_data = e_data;
        vecs.push_back(r);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [127:0] ones, zeros, d1, d2, cw, w5, t5_in, b5a;
        logic [23:0]  exp_total;
        ones  = '1;
        zeros = '0;
        d1    = 128'hFFFFFFFF_FFFFFFFF_FF000000_00000000;
        d2    = 128'h00000000_000FFFFF_FFFFFFFF_FFFFFFFF;
        cw    = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        w5    = 128'hABCDE000_00000000_00000000_00000000;
        t5_in = {20'hABCDE, {108{1'b1}}};
        b5a   = {8'h5A, 120'h0};

        // 16 bytes 0x01..0x10 make one word
        for (int k = 0; k < 16; k++)
            add(1, 128'(k + 1) << 120, 8, 1, 0, 8'(8 * k), 1, 0, 0, 0, zeros);
        add(0, zeros, 0, 1, 0, 128, 1, 1, 0, 0, 128'h01020304_05060708_090A0B0C_0D0E0F10);
        add(0, zeros, 0, 1, 0, 0,   1, 0, 0, 0, zeros);
        // stall at fill 200, release with simultaneous word and SE fire
        add(1, ones,  100, 0, 0, 0,   1, 0, 0, 0, zeros);
        add(1, ones,  100, 0, 0, 100, 1, 0, 0, 0, zeros);
        add(1, zeros, 100, 0, 0, 200, 0, 1, 0, 0, ones);
        add(1, zeros, 100, 1, 0, 200, 1, 1, 0, 0, ones);
        add(0, zeros, 0,   0, 0, 172, 0, 1, 0, 0, d1);
        add(0, zeros, 0,   1, 0, 172, 1, 1, 0, 0, d1);
        add(1, ones,  84,  1, 0, 44,  1, 0, 0, 0, zeros);
        // fill 128 with a 128-bit SE: both fire, fill stays 128
        add(1, cw,    128, 1, 0, 128, 1, 1, 0, 0, d2);
        add(0, zeros, 0,   1, 0, 128, 1, 1, 0, 0, cw);
        add(0, zeros, 0,   1, 0, 0,   1, 0, 0, 0, zeros);
        // 20-bit SE with junk below its length, then flush
        add(1, t5_in, 20, 1, 0, 0,  1, 0, 0, 0, zeros);
        add(0, zeros, 0,  0, 1, 20, 1, 0, 0, 0, zeros);
        add(0, zeros, 0,  0, 0, 20, 0, 1, 1, 0, w5);
        add(0, zeros, 0,  1, 0, 20, 0, 1, 1, 0, w5);
        add(0, zeros, 0,  1, 0, 0,  0, 0, 0, 1, zeros);
        add(0, zeros, 0,  1, 0, 0,  1, 0, 0, 0, zeros);
        // flush on empty; flush_req during FLUSH/DONE is ignored
        add(0, zeros, 0, 1, 1, 0, 1, 0, 0, 0, zeros);
        add(0, zeros, 0, 1, 1, 0, 0, 0, 0, 0, zeros);
        add(0, zeros, 0, 1, 1, 0, 0, 0, 0, 1, zeros);
        add(0, zeros, 0, 1, 0, 0, 1, 0, 0, 0, zeros);
        // SE accepted in the same cycle as flush_req
        add(1, b5a,   8, 1, 1, 0, 1, 0, 0, 0, zeros);
        add(0, zeros, 0, 1, 0, 8, 0, 1, 1, 0, b5a);
        add(0, zeros, 0, 1, 0, 0, 0, 0, 0, 1, zeros);
        add(0, zeros, 0, 1, 0, 0, 1, 0, 0, 0, zeros);

        exp_total = '0;
        foreach (vecs[i])
            if (vecs[i].v && vecs[i].e_rdy)
                exp_total += 24'((vecs[i].len > 8'd128) ? 8'd128 : vecs[i].len);

        // reset state
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_word_valid", 128'(word_valid), 128'(0));
        chk("rst_fill", 128'(fill_level), 128'(0));
        chk("rst_se_ready", 128'(se_ready), 128'(1));
        chk("rst_bits_total", 128'(bits_total), 128'(0));
        chk("rst_flush_done", 128'(flush_done), 128'(0));
        chk("rst_err_len", 128'(err_len), 128'(0));

        foreach (vecs[i]) begin
            @(negedge clk);
            se_valid = vecs[i].v; se_bits = vecs[i].bits; se_len = vecs[i].len;
            word_ready = vecs[i].wr; flush_req = vecs[i].fl;
            #1;
            chk($sformatf("row%0d_fill", i), 128'(fill_level), 128'(vecs[i].e_fill));
            chk($sformatf("row%0d_se_ready", i), 128'(se_ready), 128'(vecs[i].e_rdy));
            chk($sformatf("row%0d_word_valid", i), 128'(word_valid), 128'(vecs[i].e_wvld));
            chk($sformatf("row%0d_word_last", i), 128'(word_last), 128'(vecs[i].e_last));
            chk($sformatf("row%0d_flush_done", i), 128'(flush_done), 128'(vecs[i].e_done));
            if (vecs[i].e_wvld)
                chk($sformatf("row%0d_word_data", i), word_data, vecs[i].e_data);
        end
        @(negedge clk);
        se_valid = 1'b0; flush_req = 1'b0; word_ready = 1'b0;
        #1;
        chk("table_bits_total", 128'(bits_total), 128'(exp_total));
        chk("table_err_len", 128'(err_len), 128'(0));

        // over-length SE: clipped to 128, sticky error
        se_valid = 1'b1; se_bits = ones; se_len = 8'd200;
        #1;
        chk("err_se_ready", 128'(se_ready), 128'(1));
        @(negedge clk);
        se_valid = 1'b0; se_len = 8'd0;
        #1;
        chk("err_len_set", 128'(err_len), 128'(1));
        chk("err_fill", 128'(fill_level), 128'(128));
        chk("err_bits_total", 128'(bits_total), 128'(exp_total + 24'd128));
        chk("err_word_data", word_data, ones);

        // start a flush with the word held, then reset mid-drain
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        #1;
        chk("drain_word_valid", 128'(word_valid), 128'(1));
        chk("drain_word_last", 128'(word_last), 128'(1));
        chk("drain_se_ready", 128'(se_ready), 128'(0));
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_word_valid", 128'(word_valid), 128'(0));
        chk("midrst_word_last", 128'(word_last), 128'(0));
        chk("midrst_fill", 128'(fill_level), 128'(0));
        chk("midrst_bits_total", 128'(bits_total), 128'(0));
        chk("midrst_err_len", 128'(err_len), 128'(0));
        chk("midrst_word_data", word_data, zeros);
        @(negedge clk);
        rstn = 1'b1;
        word_ready = 1'b1;
        #1;
        chk("post_rst_se_ready", 128'(se_ready), 128'(1));
        @(negedge clk);
        #1;
        chk("post_rst_no_word", 128'(word_valid), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
